// File: rtl/tdm_demux4_if.sv
// Serial-in / four-lane-out bundle for tdm_demux4; the demux attaches to the slave modport.
interface tdm_demux4_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_vld;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             out_vld;
    logic [1:0]       slot;
    logic             err;

    modport master (
        output in_vld, in_sof, in_data,
        input  out0, out1, out2, out3, out_vld, slot, err
    );

    modport slave (
        input  in_vld, in_sof, in_data,
        output out0, out1, out2, out3, out_vld, slot, err
    );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: stages a frame in shadow registers and loads all lanes at once.
// Define TDM_DEMUX4_TIMEOUT_EN to drop frames that stall for TIMEOUT idle cycles.
module tdm_demux4 #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst,
    tdm_demux4_if.slave bus
);
    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end

    logic [0:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic             out_vld_q, out_vld_d;
    logic             err_q, err_d;

`ifdef TDM_DEMUX4_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shadow_d  = shadow_q;
        lane_d    = lane_q;
        out_vld_d = 1'b0;
        err_d     = 1'b0;
`ifdef TDM_DEMUX4_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        case (state_q)
            StIdle: begin
                if (bus.in_vld && bus.in_sof) begin
                    shadow_d[0] = bus.in_data;
                    slot_d      = 2'd1;
                    state_d     = StRun;
                end
            end
            default: begin
                if (bus.in_vld) begin
                    if (bus.in_sof) begin
                        // Resync: drop the partial frame and treat this beat as slot 0.
                        err_d       = 1'b1;
                        shadow_d[0] = bus.in_data;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        lane_d[0] = shadow_q[0];
                        lane_d[1] = shadow_q[1];
                        lane_d[2] = shadow_q[2];
                        lane_d[3] = bus.in_data;
                        out_vld_d = 1'b1;
                        slot_d    = 2'd0;
                        state_d   = StIdle;
                    end else begin
                        shadow_d[slot_q] = bus.in_data;
                        slot_d           = slot_q + 2'd1;
                    end
                end else begin
`ifdef TDM_DEMUX4_TIMEOUT_EN
                    // Count reaches TIMEOUT on this edge; a beat in this cycle would have won.
                    if (idle_cnt_q == CntW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        slot_d  = 2'd0;
                        state_d = StIdle;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            slot_q    <= 2'd0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) lane_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
            lane_q    <= lane_d;
        end
    end

`ifdef TDM_DEMUX4_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_cnt_q <= '0;
        else     idle_cnt_q <= idle_cnt_d;
    end
`endif

    assign bus.out0    = lane_q[0];
    assign bus.out1    = lane_q[1];
    assign bus.out2    = lane_q[2];
    assign bus.out3    = lane_q[3];
    assign bus.out_vld = out_vld_q;
    assign bus.slot    = slot_q;
    assign bus.err     = err_q;
endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer that rebuilds four parallel lanes from one serial stream produced by a 4:1 mux whose select steps through 0,1,2,3. It tracks frame position with a slot counter keyed on a start-of-frame marker, and stages each frame in shadow registers. It updates all four outputs at once with a one-cycle valid pulse. It is the receive end of the lab's 4:1 multiplexer path.

## Interface
- `WIDTH`, default 1: data width of each lane and of the serial input.
- `TIMEOUT`, default 15: idle-cycle limit within a frame; used only with `TDM_DEMUX4_TIMEOUT_EN`.

Ports:
- `clk`  in  1: the only clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_vld`  in  1: a serial beat is present this cycle.
- `in_sof`  in  1: the beat is slot 0 of a frame; ignored when `in_vld`=0.
- `in_data`  in  WIDTH: serial data.
- `out0`, `out1`, `out2`, `out3`  out  WIDTH each: reconstructed lanes, registered.
- `out_vld`  out  1: one-cycle pulse; `out0`–`out3` hold a new complete frame.
- `slot`  out  2: next expected slot index.
- `err`  out  1: one-cycle pulse on a frame error.

## Operation
- States:
  - IDLE: waiting for a start of frame.
  - RUN: inside a frame.
- On reset:
  - State goes to IDLE; shadow registers are cleared.
  - `out0`–`out3`=0, `out_vld`=0, `slot`=0, `err`=0.
- IDLE:
  - `in_vld`=1 with `in_sof`=0: beat discarded, no error.
  - `in_vld`=1 with `in_sof`=1: `in_data` goes to shadow[0], `slot`→1, state→RUN.
- RUN, `in_vld`=1 with `in_sof`=0:
  - `in_data` goes to shadow[`slot`] and `slot` increments.
  - On slot 3, all lanes load at once: `out0..out2`←shadow[0..2], `out3`←`in_data`.
  - Also on slot 3: `out_vld` pulses, `slot` wraps to 0, state→IDLE.
- RUN, `in_vld`=0: everything holds (gaps are legal).
- RUN, `in_vld`=1 with `in_sof`=1 (this includes the slot-3 beat):
  - `err` pulses and the partial frame is dropped; the outputs keep their last frame and `out_vld` stays 0.
  - The beat is taken as a new slot 0: shadow[0]←`in_data`, `slot`→1, state stays RUN.
- `out0`–`out3` change only on an `out_vld` edge or on reset. They are never partially updated.
- Back-to-back frames are supported: a `sof` beat in the cycle right after a slot-3 beat starts the next frame with no bubble.

## Timing
- The final beat is sampled at edge N. `out0`–`out3` and `out_vld`=1 are visible after edge N, and `out_vld` returns to 0 after edge N+1.
- A full frame with no gaps takes 4 input cycles; outputs appear 1 cycle after the last beat.
- `err` is asserted for the single cycle after the edge that detected the error.
- `slot` is registered and updates on the same edge as the beat it counts.
- Reset asserted mid-frame clears all outputs immediately, without waiting for a clock edge. After deassertion, the first accepted beat must carry `sof`.

## Configuration
- `TDM_DEMUX4_TIMEOUT_EN` defined:
  - An idle counter of $clog2(TIMEOUT+1) bits counts RUN cycles with `in_vld`=0 and clears on any accepted beat.
  - When it reaches `TIMEOUT`, `err` pulses, the partial frame is dropped, `slot`→0 and state→IDLE.
  - If a beat arrives in the same cycle the count is reached, the beat wins and there is no timeout.
- Not defined: no counter is built and RUN waits indefinitely for the remaining beats.

## Test plan
Tests run with WIDTH=4.
1. Clean frame: beats A,5,C,3 on consecutive cycles, `sof` on A → one `out_vld` pulse 1 cycle after the 3, with `out0`..`out3`=A,5,C,3 and `err`=0.
2. Gapped frame: beats 1,2,3,4 with 2 idle cycles between each → same outputs as an unbroken frame, and `slot` holds during the gaps.
3. Early `sof`: 7,8 then a `sof` beat 9, followed by 1,2,3 → `err` pulses on the 9 beat, previous outputs are kept, and the next `out_vld` gives 9,1,2,3.
4. Headless stream: beats 6,6 with no `sof` in IDLE are ignored; then `sof` F,E,D,C → `out_vld` with F,E,D,C and no `err`.
5. Async reset after 2 beats of a frame → all outputs are 0 before the next edge; a following full frame decodes correctly.
6. With `TDM_DEMUX4_TIMEOUT_EN` and TIMEOUT=15: 2 beats, then 15 idle cycles → `err` pulse and `slot`=0. With 14 idle cycles and then the rest of the frame, the frame completes normally.
